// File: rtl/ciq_pkg.sv
`default_nettype none
// ============================================================================
// Package  : ciq_pkg
// Brief    : Shared widths, entry field layout and wakeup compare for the
//            centralized issue queue. Dispatch and issue/select both use
//            these constants so they agree on the entry format.
// Revision : 1.0 - initial release
// ============================================================================
package ciq_pkg;

  localparam int c_opcode_width = 7;
  localparam int c_prf_width    = 6;
  localparam int c_age_width    = 5;
  localparam int c_iq_depth     = 16;
  localparam int c_wb_ports     = 4;
  localparam int c_iq_width     = c_opcode_width + 3*c_prf_width + c_age_width + 7;
  localparam int c_cnt_width    = $clog2(c_iq_depth + 1);

  // Entry layout, LSB first
  localparam int c_free_bit     = 0;
  localparam int c_issued_bit   = 1;
  localparam int c_age_lsb      = 2;
  localparam int c_age_msb      = c_age_lsb + c_age_width - 1;
  localparam int c_prdv_bit     = c_age_msb + 1;
  localparam int c_prd_lsb      = c_prdv_bit + 1;
  localparam int c_prd_msb      = c_prd_lsb + c_prf_width - 1;
  localparam int c_prs2_rdy_bit = c_prd_msb + 1;
  localparam int c_prs2_v_bit   = c_prs2_rdy_bit + 1;
  localparam int c_prs2_lsb     = c_prs2_v_bit + 1;
  localparam int c_prs2_msb     = c_prs2_lsb + c_prf_width - 1;
  localparam int c_prs1_rdy_bit = c_prs2_msb + 1;
  localparam int c_prs1_v_bit   = c_prs1_rdy_bit + 1;
  localparam int c_prs1_lsb     = c_prs1_v_bit + 1;
  localparam int c_prs1_msb     = c_prs1_lsb + c_prf_width - 1;
  localparam int c_op_lsb       = c_prs1_msb + 1;
  localparam int c_op_msb       = c_op_lsb + c_opcode_width - 1;

  // True when any valid writeback port broadcasts the given tag.
  function automatic logic wb_tag_hit(
    input logic [c_wb_ports-1:0]             wb_valid,
    input logic [c_wb_ports*c_prf_width-1:0] wb_tag,
    input logic [c_prf_width-1:0]            tag
  );
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < c_wb_ports; k++) begin
      if (wb_valid[k] && (wb_tag[k*c_prf_width +: c_prf_width] == tag)) begin
        hit = 1'b1;
      end
    end
    return hit;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ciq_free_pick.sv
`default_nettype none
// ============================================================================
// Module   : ciq_free_pick
// Brief    : Lowest-index priority encoder over the free-entry vector, with
//            an any-free flag.
// Revision : 1.0 - initial release
// ============================================================================
module ciq_free_pick #(
  parameter int DEPTH     = 16,
  parameter int IDX_WIDTH = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]     free_vec,
  output logic [IDX_WIDTH-1:0] free_idx,
  output logic                 any_free
);

  // Scan downward so the lowest set bit is the last (winning) assignment.
  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (free_vec[i]) begin
        free_idx = IDX_WIDTH'(i);
      end
    end
  end

  assign any_free = |free_vec;

endmodule
`default_nettype wire

// File: rtl/ciq_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : ciq_dispatch
// Brief    : Write side of the 16-entry centralized issue queue. Allocates
//            the lowest free entry per dispatch, maintains unique relative
//            ages, applies writeback wakeups, marks grants as issued and
//            frees issued entries one cycle later.
// Revision : 1.0 - initial release
// ============================================================================
module ciq_dispatch
  import ciq_pkg::*;
#(
  parameter int OPCODE_WIDTH = c_opcode_width,
  parameter int PRF_WIDTH    = c_prf_width,
  parameter int AGE_WIDTH    = c_age_width,
  parameter int IQ_DEPTH     = c_iq_depth,
  parameter int WB_PORTS     = c_wb_ports,
  parameter int IQ_WIDTH     = c_iq_width
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          disp_valid,
  output logic                          disp_ready,
  input  logic [OPCODE_WIDTH-1:0]       disp_op,
  input  logic [PRF_WIDTH-1:0]          disp_prs1,
  input  logic [PRF_WIDTH-1:0]          disp_prs2,
  input  logic [PRF_WIDTH-1:0]          disp_prd,
  input  logic                          disp_prs1_v,
  input  logic                          disp_prs2_v,
  input  logic                          disp_prd_v,
  input  logic                          disp_prs1_busy,
  input  logic                          disp_prs2_busy,
  input  logic [WB_PORTS-1:0]           wb_valid,
  input  logic [WB_PORTS*PRF_WIDTH-1:0] wb_tag,
  input  logic [IQ_DEPTH-1:0]           iss_grant,
  output logic [IQ_DEPTH*IQ_WIDTH-1:0]  ciq_flat,
  output logic [c_cnt_width-1:0]        free_count
);

  localparam int c_idx_width = $clog2(IQ_DEPTH);
  localparam logic [IQ_WIDTH-1:0] c_entry_reset = IQ_WIDTH'(1) << c_free_bit;

  logic [IQ_DEPTH-1:0]                w_free_vec;
  logic [IQ_DEPTH-1:0]                w_retire;
  logic [IQ_DEPTH-1:0][AGE_WIDTH-1:0] w_ages;
  logic [c_idx_width-1:0]             w_pick_idx;
  logic                               w_any_free;
  logic                               w_fire;
  logic                               w_disp_rdy1;
  logic                               w_disp_rdy2;
  logic [c_cnt_width-1:0]             w_retire_cnt;
  logic [c_cnt_width-1:0]             r_free_count;

  ciq_free_pick #(
    .DEPTH     (IQ_DEPTH),
    .IDX_WIDTH (c_idx_width)
  ) u_free_pick (
    .free_vec (w_free_vec),
    .free_idx (w_pick_idx),
    .any_free (w_any_free)
  );

  assign disp_ready = (r_free_count != '0);
  assign free_count = r_free_count;
  assign w_fire     = disp_valid & disp_ready & w_any_free & ~flush;

  // An operand is ready at dispatch if unused, already produced, or
  // broadcast on a writeback port in this very cycle.
  assign w_disp_rdy1 = ~disp_prs1_v | ~disp_prs1_busy | wb_tag_hit(wb_valid, wb_tag, disp_prs1);
  assign w_disp_rdy2 = ~disp_prs2_v | ~disp_prs2_busy | wb_tag_hit(wb_valid, wb_tag, disp_prs2);

  for (genvar e = 0; e < IQ_DEPTH; e++) begin : g_entry
    logic [IQ_WIDTH-1:0]  r_entry;
    logic [IQ_WIDTH-1:0]  w_nxt;
    logic [AGE_WIDTH-1:0] w_younger_frees;
    logic                 w_live;

    assign w_live        = ~r_entry[c_free_bit];
    assign w_free_vec[e] = r_entry[c_free_bit];
    assign w_retire[e]   = w_live & r_entry[c_issued_bit];
    assign w_ages[e]     = r_entry[c_age_msb:c_age_lsb];
    assign ciq_flat[e*IQ_WIDTH +: IQ_WIDTH] = r_entry;

    // Count entries retiring this cycle that are younger (smaller age).
    always_comb begin
      w_younger_frees = '0;
      for (int j = 0; j < IQ_DEPTH; j++) begin
        if (w_retire[j] && (w_ages[j] < w_ages[e])) begin
          w_younger_frees = w_younger_frees + AGE_WIDTH'(1);
        end
      end
    end

    // Slot next state: flush, retire after issue, live update, or allocation.
    always_comb begin
      w_nxt = r_entry;
      if (flush || w_retire[e]) begin
        w_nxt[c_free_bit]   = 1'b1;
        w_nxt[c_issued_bit] = 1'b0;
      end else if (w_live) begin
        w_nxt[c_age_msb:c_age_lsb] = w_ages[e] + AGE_WIDTH'(w_fire) - w_younger_frees;
        if (r_entry[c_prs1_v_bit] &&
            wb_tag_hit(wb_valid, wb_tag, r_entry[c_prs1_msb:c_prs1_lsb])) begin
          w_nxt[c_prs1_rdy_bit] = 1'b1;
        end
        if (r_entry[c_prs2_v_bit] &&
            wb_tag_hit(wb_valid, wb_tag, r_entry[c_prs2_msb:c_prs2_lsb])) begin
          w_nxt[c_prs2_rdy_bit] = 1'b1;
        end
        // Live and not retiring implies ISSUED=0, so a grant is honoured.
        if (iss_grant[e]) begin
          w_nxt[c_issued_bit] = 1'b1;
        end
      end else if (w_fire && (w_pick_idx == c_idx_width'(e))) begin
        w_nxt                            = '0;
        w_nxt[c_op_msb:c_op_lsb]         = disp_op;
        w_nxt[c_prs1_msb:c_prs1_lsb]     = disp_prs1;
        w_nxt[c_prs1_v_bit]              = disp_prs1_v;
        w_nxt[c_prs1_rdy_bit]            = w_disp_rdy1;
        w_nxt[c_prs2_msb:c_prs2_lsb]     = disp_prs2;
        w_nxt[c_prs2_v_bit]              = disp_prs2_v;
        w_nxt[c_prs2_rdy_bit]            = w_disp_rdy2;
        w_nxt[c_prd_msb:c_prd_lsb]       = disp_prd;
        w_nxt[c_prdv_bit]                = disp_prd_v;
      end
    end

    // Entry register.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_entry <= c_entry_reset;
      end else begin
        r_entry <= w_nxt;
      end
    end
  end

  // Number of entries returning to the free pool this cycle.
  always_comb begin
    w_retire_cnt = '0;
    for (int i = 0; i < IQ_DEPTH; i++) begin
      w_retire_cnt = w_retire_cnt + c_cnt_width'(w_retire[i]);
    end
  end

  // Free-entry counter: +retires -dispatch, reloaded on flush.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_free_count <= c_cnt_width'(IQ_DEPTH);
    end else begin
      r_free_count <= r_free_count + w_retire_cnt - c_cnt_width'(w_fire);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ciq_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : tb_ciq_dispatch
// Brief    : Self-checking bench for ciq_dispatch: directed vector table,
//            hand-written corner sequences and random traffic against a
//            sequence-number reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ciq_dispatch;

  localparam int W = 37;
  localparam int D = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          disp_valid = 1'b0;
  logic          disp_ready;
  logic [6:0]    disp_op = '0;
  logic [5:0]    disp_prs1 = '0, disp_prs2 = '0, disp_prd = '0;
  logic          disp_prs1_v = 1'b0, disp_prs2_v = 1'b0, disp_prd_v = 1'b0;
  logic          disp_prs1_busy = 1'b0, disp_prs2_busy = 1'b0;
  logic [3:0]    wb_valid = '0;
  logic [23:0]   wb_tag = '0;
  logic [15:0]   iss_grant = '0;
  logic [D*W-1:0] ciq_flat;
  logic [4:0]    free_count;

  always #5 clk = ~clk;

  ciq_dispatch dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .disp_valid     (disp_valid),
    .disp_ready     (disp_ready),
    .disp_op        (disp_op),
    .disp_prs1      (disp_prs1),
    .disp_prs2      (disp_prs2),
    .disp_prd       (disp_prd),
    .disp_prs1_v    (disp_prs1_v),
    .disp_prs2_v    (disp_prs2_v),
    .disp_prd_v     (disp_prd_v),
    .disp_prs1_busy (disp_prs1_busy),
    .disp_prs2_busy (disp_prs2_busy),
    .wb_valid       (wb_valid),
    .wb_tag         (wb_tag),
    .iss_grant      (iss_grant),
    .ciq_flat       (ciq_flat),
    .free_count     (free_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ent(input int e);
    return ciq_flat[e*W +: W];
  endfunction

  // ---------------- reference model: slots tagged with dispatch order -----
  typedef struct {
    bit          live;
    bit          issued;
    int unsigned seq;
    bit [6:0]    op;
    bit [5:0]    prs1, prs2, prd;
    bit          v1, v2, vd, r1, r2;
  } slot_t;

  slot_t       m [D];
  int unsigned seq_ctr = 0;

  function automatic bit m_hit(input bit [5:0] tag);
    for (int k = 0; k < 4; k++)
      if (wb_valid[k] && wb_tag[k*6 +: 6] == tag) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_reset();
    for (int e = 0; e < D; e++) begin
      m[e].live = 1'b0;
      m[e].issued = 1'b0;
    end
  endfunction

  function automatic int m_free();
    int n = 0;
    for (int e = 0; e < D; e++) if (!m[e].live) n++;
    return n;
  endfunction

  // Age = number of live entries dispatched later than this one.
  function automatic logic [W-1:0] m_entry(input int e);
    int age = 0;
    for (int j = 0; j < D; j++)
      if (m[j].live && m[j].seq > m[e].seq) age++;
    return {m[e].op, m[e].prs1, m[e].v1, m[e].r1, m[e].prs2, m[e].v2, m[e].r2,
            m[e].prd, m[e].vd, 5'(age), m[e].issued, 1'b0};
  endfunction

  function automatic void model_step();
    slot_t nm [D];
    int    pick;
    nm = m;
    if (flush) begin
      model_reset();
      return;
    end
    pick = -1;
    for (int e = D - 1; e >= 0; e--) if (!m[e].live) pick = e;
    for (int e = 0; e < D; e++) begin
      if (m[e].live && m[e].issued) begin
        nm[e].live = 1'b0;
        nm[e].issued = 1'b0;
      end else if (m[e].live) begin
        if (m[e].v1 && m_hit(m[e].prs1)) nm[e].r1 = 1'b1;
        if (m[e].v2 && m_hit(m[e].prs2)) nm[e].r2 = 1'b1;
        if (iss_grant[e]) nm[e].issued = 1'b1;
      end
    end
    if (disp_valid && pick >= 0) begin
      nm[pick].live   = 1'b1;
      nm[pick].issued = 1'b0;
      nm[pick].seq    = seq_ctr;
      nm[pick].op     = disp_op;
      nm[pick].prs1   = disp_prs1;
      nm[pick].prs2   = disp_prs2;
      nm[pick].prd    = disp_prd;
      nm[pick].v1     = disp_prs1_v;
      nm[pick].v2     = disp_prs2_v;
      nm[pick].vd     = disp_prd_v;
      nm[pick].r1     = !disp_prs1_v || !disp_prs1_busy || m_hit(disp_prs1);
      nm[pick].r2     = !disp_prs2_v || !disp_prs2_busy || m_hit(disp_prs2);
      seq_ctr++;
    end
    m = nm;
  endfunction

  task automatic check_model();
    logic [W-1:0] x;
    for (int e = 0; e < D; e++) begin
      x = ent(e);
      if (!m[e].live) chk($sformatf("model_entry%0d_free", e), 64'(x[0]), 64'd1);
      else            chk($sformatf("model_entry%0d", e), 64'(x), 64'(m_entry(e)));
    end
    chk("model_free_count", 64'(free_count), 64'(m_free()));
    chk("model_disp_ready", 64'(disp_ready), 64'(m_free() != 0));
  endtask

  // Inputs are already applied; advance one clock and compare with the model.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic drive_idle();
    flush = 1'b0; disp_valid = 1'b0; disp_op = '0;
    disp_prs1 = '0; disp_prs2 = '0; disp_prd = '0;
    disp_prs1_v = 1'b0; disp_prs2_v = 1'b0; disp_prd_v = 1'b0;
    disp_prs1_busy = 1'b0; disp_prs2_busy = 1'b0;
    wb_valid = '0; wb_tag = '0; iss_grant = '0;
  endtask

  task automatic drive_disp(input logic [6:0] op, input logic [5:0] s1, input logic [5:0] s2,
                            input logic [5:0] d, input logic b1, input logic b2);
    disp_valid = 1'b1; disp_op = op;
    disp_prs1 = s1; disp_prs2 = s2; disp_prd = d;
    disp_prs1_v = 1'b1; disp_prs2_v = 1'b1; disp_prd_v = 1'b1;
    disp_prs1_busy = b1; disp_prs2_busy = b2;
  endtask

  task automatic chk_field(input string name, input int e, input int lsb, input int w, input int exp);
    logic [W-1:0] x;
    logic [63:0]  f;
    x = ent(e);
    f = 64'(x >> lsb) & ((64'd1 << w) - 64'd1);
    chk(name, f, 64'(exp));
  endtask

  // ---------------- directed vector table ---------------------------------
  typedef struct {
    bit        val;
    bit [6:0]  op;
    bit [5:0]  s1, s2, d;
    bit        s1v, s2v, dvv, b1, b2;
    bit [3:0]  wbv;
    bit [23:0] wbt;
    bit [15:0] gnt;
    int        ce;
    bit        ef, ei;
    bit [4:0]  ea;
    bit        er1, er2;
    bit [4:0]  ecnt;
    bit        erdy;
  } vec_t;

  vec_t tbl [13];

  initial begin
    tbl[0]  = '{default:0, val:1, op:7'h11, s1:1, s2:2, d:3, s1v:1, s2v:1, dvv:1,
                ce:0, ea:0, er1:1, er2:1, ecnt:15, erdy:1};
    tbl[1]  = '{default:0, val:1, op:7'h12, s1:4, s2:5, d:6, s1v:1, s2v:1, dvv:1, b1:1,
                ce:1, ea:0, er1:0, er2:1, ecnt:14, erdy:1};
    tbl[2]  = '{default:0, val:1, op:7'h13, s1:7, s2:8, d:9, s1v:1, s2v:1, dvv:1,
                ce:2, ea:0, er1:1, er2:1, ecnt:13, erdy:1};
    tbl[3]  = '{default:0, ce:0, ea:2, er1:1, er2:1, ecnt:13, erdy:1};
    tbl[4]  = '{default:0, ce:1, ea:1, er1:0, er2:1, ecnt:13, erdy:1};
    tbl[5]  = '{default:0, val:1, op:7'h14, s1:5, s2:9, d:10, s1v:1, s2v:1, dvv:1, b1:1, b2:1,
                wbv:4'b0100, wbt:24'h005000, ce:3, ea:0, er1:1, er2:0, ecnt:12, erdy:1};
    tbl[6]  = '{default:0, val:1, op:7'h15, s1:12, s2:13, d:14, s1v:1, s2v:0, dvv:1, b1:1, b2:1,
                ce:4, ea:0, er1:0, er2:1, ecnt:11, erdy:1};
    tbl[7]  = '{default:0, wbv:4'b0001, wbt:24'h00000c, ce:4, ea:0, er1:1, er2:1, ecnt:11, erdy:1};
    tbl[8]  = '{default:0, gnt:16'h0001, ce:0, ei:1, ea:4, er1:1, er2:1, ecnt:11, erdy:1};
    tbl[9]  = '{default:0, ce:0, ef:1, ecnt:12, erdy:1};
    tbl[10] = '{default:0, ce:1, ea:3, er1:0, er2:1, ecnt:12, erdy:1};
    tbl[11] = '{default:0, wbv:4'b1000, wbt:24'h100000, ce:1, ea:3, er1:1, er2:1, ecnt:12, erdy:1};
    tbl[12] = '{default:0, val:1, op:7'h16, s1:1, s2:2, d:3, s1v:1, s2v:1, dvv:1,
                ce:0, ea:0, er1:1, er2:1, ecnt:11, erdy:1};

    // Reset state
    drive_idle();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    for (int e = 0; e < D; e++) chk($sformatf("reset_entry%0d", e), 64'(ent(e)), 64'd1);
    chk("reset_free_count", 64'(free_count), 64'd16);
    chk("reset_disp_ready", 64'(disp_ready), 64'd1);

    // Table-driven vectors
    for (int i = 0; i < 13; i++) begin
      drive_idle();
      disp_valid = tbl[i].val; disp_op = tbl[i].op;
      disp_prs1 = tbl[i].s1; disp_prs2 = tbl[i].s2; disp_prd = tbl[i].d;
      disp_prs1_v = tbl[i].s1v; disp_prs2_v = tbl[i].s2v; disp_prd_v = tbl[i].dvv;
      disp_prs1_busy = tbl[i].b1; disp_prs2_busy = tbl[i].b2;
      wb_valid = tbl[i].wbv; wb_tag = tbl[i].wbt; iss_grant = tbl[i].gnt;
      cycle();
      chk($sformatf("vec%0d_free_count", i), 64'(free_count), 64'(tbl[i].ecnt));
      chk($sformatf("vec%0d_disp_ready", i), 64'(disp_ready), 64'(tbl[i].erdy));
      chk_field($sformatf("vec%0d_free", i), tbl[i].ce, 0, 1, int'(tbl[i].ef));
      if (!tbl[i].ef) begin
        chk_field($sformatf("vec%0d_issued", i), tbl[i].ce, 1, 1, int'(tbl[i].ei));
        chk_field($sformatf("vec%0d_age", i), tbl[i].ce, 2, 5, int'(tbl[i].ea));
        chk_field($sformatf("vec%0d_prs1_rdy", i), tbl[i].ce, 22, 1, int'(tbl[i].er1));
        chk_field($sformatf("vec%0d_prs2_rdy", i), tbl[i].ce, 14, 1, int'(tbl[i].er2));
      end
    end

    // Fill all 16, grant entry 7, observe shadow free and reallocation
    drive_idle(); flush = 1'b1; cycle();
    chk("flush_free_count", 64'(free_count), 64'd16);
    for (int i = 0; i < D; i++) begin
      drive_idle(); drive_disp(7'(i), 6'(i), 6'(i + 1), 6'(i + 2), 1'b1, 1'b1); cycle();
    end
    chk("full_disp_ready", 64'(disp_ready), 64'd0);
    chk("full_free_count", 64'(free_count), 64'd0);
    chk_field("full_entry0_age", 0, 2, 5, 15);
    drive_idle(); iss_grant = 16'h0080; cycle();
    chk_field("grant7_issued", 7, 1, 1, 1);
    chk("grant7_disp_ready_t1", 64'(disp_ready), 64'd0);
    drive_idle(); cycle();
    chk_field("grant7_free_t2", 7, 0, 1, 1);
    chk("grant7_disp_ready_t2", 64'(disp_ready), 64'd1);
    drive_idle(); drive_disp(7'h55, 6'd3, 6'd4, 6'd5, 1'b0, 1'b0); cycle();
    chk_field("realloc7_free", 7, 0, 1, 0);
    chk_field("realloc7_age", 7, 2, 5, 0);
    chk_field("realloc_entry0_age", 0, 2, 5, 15);

    // Two frees in one cycle compact the older ages
    drive_idle(); flush = 1'b1; cycle();
    for (int i = 0; i < 4; i++) begin
      drive_idle(); drive_disp(7'(i), 6'(i), 6'(i), 6'(i), 1'b0, 1'b0); cycle();
    end
    chk_field("age4_entry0", 0, 2, 5, 3);
    drive_idle(); iss_grant = 16'b1010; cycle();
    drive_idle(); cycle();
    chk_field("dualfree_entry0_age", 0, 2, 5, 1);
    chk_field("dualfree_entry2_age", 2, 2, 5, 0);
    chk_field("dualfree_entry1_free", 1, 0, 1, 1);
    chk("dualfree_free_count", 64'(free_count), 64'd14);

    // Flush beats a same-cycle dispatch and grant
    drive_idle(); drive_disp(7'h7f, 6'd1, 6'd2, 6'd3, 1'b0, 1'b0);
    iss_grant = 16'h0001; flush = 1'b1; cycle();
    chk("flushmix_free_count", 64'(free_count), 64'd16);
    chk("flushmix_disp_ready", 64'(disp_ready), 64'd1);
    for (int e = 0; e < D; e++) chk_field($sformatf("flushmix_free%0d", e), e, 0, 1, 1);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      drive_idle();
      flush = ($urandom_range(0, 63) == 0);
      disp_valid = ($urandom_range(0, 99) < 65);
      disp_op = 7'($urandom_range(0, 127));
      disp_prs1 = 6'($urandom_range(0, 15));
      disp_prs2 = 6'($urandom_range(0, 15));
      disp_prd = 6'($urandom_range(0, 63));
      disp_prs1_v = ($urandom_range(0, 3) != 0);
      disp_prs2_v = ($urandom_range(0, 3) != 0);
      disp_prd_v = ($urandom_range(0, 3) != 0);
      disp_prs1_busy = 1'($urandom_range(0, 1));
      disp_prs2_busy = 1'($urandom_range(0, 1));
      wb_valid = 4'($urandom_range(0, 15));
      for (int k = 0; k < 4; k++) wb_tag[k*6 +: 6] = 6'($urandom_range(0, 15));
      for (int e = 0; e < D; e++)
        if (m[e].live && !m[e].issued && $urandom_range(0, 3) == 0) iss_grant[e] = 1'b1;
      cycle();
    end

    // Reset dominates flush, dispatch and grant
    drive_idle(); drive_disp(7'h01, 6'd1, 6'd1, 6'd1, 1'b0, 1'b0);
    flush = 1'b1; iss_grant = 16'hffff; rst = 1'b1;
    @(posedge clk);
    #1;
    for (int e = 0; e < D; e++) chk($sformatf("rst2_entry%0d", e), 64'(ent(e)), 64'd1);
    chk("rst2_free_count", 64'(free_count), 64'd16);
    chk("rst2_disp_ready", 64'(disp_ready), 64'd1);
    rst = 1'b0;
    drive_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
